// File: rtl/cic_decimator.sv
// Third-order CIC decimator for a 1-bit delta-sigma bitstream.
// Integrators run at the input sample rate; a tick every R accepted samples
// captures the last integrator into a comb pipeline that carries a valid
// token, followed by an arithmetic-shift/saturate stage and the output register.
module cic_decimator #(
    parameter int W     = 16,
    parameter int ORDER = 3,
    parameter int R     = 64,
    parameter int LOG2R = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din_valid,
    input  logic                din,
    output logic signed [W-1:0] dout,
    output logic                dout_valid
);

    localparam int B     = 2 + ORDER * LOG2R;
    localparam int SHIFT = ORDER * LOG2R - (W - 1);
    // A negative shift (small R) becomes a left shift on a widened value.
    localparam int LSH   = (SHIFT < 0) ? -SHIFT : 0;
    localparam int RSH   = (SHIFT > 0) ? SHIFT : 0;
    localparam int SW    = B + LSH;
    localparam logic signed [SW-1:0] MAXV = SW'((2 ** (W - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = SW'(-(2 ** (W - 1)));

    // +1 / -1 in B-bit two's complement
    logic [B-1:0] x;
    assign x = din ? B'(1) : {B{1'b1}};

    logic [ORDER-1:0][B-1:0] integ_reg;
    logic [ORDER-1:0][B-1:0] integ_next;
    logic [LOG2R-1:0]        cnt_reg;
    logic                    tick;

    assign tick = din_valid && (cnt_reg == LOG2R'(R - 1));

    // Next-value chain: each stage sees the already-updated previous stage, so
    // the last integrator includes the current sample in the same edge.
    genvar gi;
    generate
        for (gi = 0; gi < ORDER; gi++) begin : g_integ
            if (gi == 0) begin : g_first
                assign integ_next[gi] = integ_reg[gi] + x;
            end else begin : g_rest
                assign integ_next[gi] = integ_reg[gi] + integ_next[gi-1];
            end
        end
    endgenerate

    // Integrators and decimation counter advance only on accepted samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            integ_reg <= '0;
            cnt_reg   <= '0;
        end else if (din_valid) begin
            integ_reg <= integ_next;
            cnt_reg   <= cnt_reg + LOG2R'(1);
        end
    end

    logic [B-1:0] cap_reg;
    logic         cap_vld_reg;

    // Capture the last integrator on each tick and launch a valid token.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_reg     <= '0;
            cap_vld_reg <= 1'b0;
        end else begin
            cap_vld_reg <= tick;
            if (tick) begin
                cap_reg <= integ_next[ORDER-1];
            end
        end
    end

    logic [ORDER-1:0][B-1:0] comb_in;
    logic [ORDER-1:0][B-1:0] comb_diff;
    logic [ORDER-1:0][B-1:0] comb_data_reg;
    logic [ORDER-1:0][B-1:0] comb_dly_reg;
    logic [ORDER-1:0]        comb_vin;
    logic [ORDER-1:0]        comb_vld_reg;

    generate
        for (gi = 0; gi < ORDER; gi++) begin : g_comb
            if (gi == 0) begin : g_first
                assign comb_in[gi]  = cap_reg;
                assign comb_vin[gi] = cap_vld_reg;
            end else begin : g_rest
                assign comb_in[gi]  = comb_data_reg[gi-1];
                assign comb_vin[gi] = comb_vld_reg[gi-1];
            end
            assign comb_diff[gi] = comb_in[gi] - comb_dly_reg[gi];
        end
    endgenerate

    // Comb pipeline: data/tokens move every cycle, delay elements only on tokens.
    always_ff @(posedge clk) begin
        if (rst) begin
            comb_data_reg <= '0;
            comb_dly_reg  <= '0;
            comb_vld_reg  <= '0;
        end else begin
            comb_data_reg <= comb_diff;
            comb_vld_reg  <= comb_vin;
            for (int k = 0; k < ORDER; k++) begin
                if (comb_vin[k]) begin
                    comb_dly_reg[k] <= comb_in[k];
                end
            end
        end
    end

    logic signed [B-1:0]  c_last;
    logic signed [SW-1:0] ext;
    logic signed [SW-1:0] shifted;
    logic signed [W-1:0]  sat_val;

    assign c_last  = comb_data_reg[ORDER-1];
    assign ext     = SW'(c_last);
    assign shifted = (ext <<< LSH) >>> RSH;

    // Clamp the scaled comb output into the W-bit signed range.
    always_comb begin
        sat_val = shifted[W-1:0];
        if (shifted > MAXV) begin
            sat_val = MAXV[W-1:0];
        end else if (shifted < MINV) begin
            sat_val = MINV[W-1:0];
        end
    end

    logic signed [W-1:0] sc_reg;
    logic                sc_vld_reg;

    // Scale stage then output register; dout holds between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sc_reg     <= '0;
            sc_vld_reg <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            sc_reg     <= sat_val;
            sc_vld_reg <= comb_vld_reg[ORDER-1];
            dout_valid <= sc_vld_reg;
            if (sc_vld_reg) begin
                dout <= sc_reg;
            end
        end
    end

endmodule
